// File: rtl/md_pkg.sv
// md_pkg: state and opcode encodings shared by md_sequencer and the control unit that drives it.
package md_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: request/result bundle between the control unit (master) and md_sequencer (slave).
interface md_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic                    start;
    logic                    op;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic                    busy;
    logic                    done;
    logic                    div0;
    logic                    WriteHI;
    logic                    WriteLO;
    logic signed [WIDTH-1:0] hi;
    logic signed [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div0, WriteHI, WriteLO, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div0, WriteHI, WriteLO, hi, lo
    );
endinterface

// File: rtl/md_abs_neg.sv
// md_abs_neg: conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module md_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_neg ? ('0 - i_x) : i_x;
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: iterative signed MULT (radix-2 Booth) / DIV (restoring) unit writing HI/LO.
// Optional MD_SHORTCUT_EN: zero-operand MULT and |a|<|b| DIV complete on the accept edge.
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_resert,
    md_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e               r_state, w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [WIDTH:0]   r_acc, r_m;
    logic [WIDTH-1:0]        r_q;
    logic                    r_qm1, r_qneg, r_rneg;
    logic signed [WIDTH-1:0] r_hi, r_lo;
    logic                    r_done, r_div0, r_wr;

    logic                    w_accept, w_step, w_fin, w_div0, w_short;
    logic [WIDTH-1:0]        w_abs_a, w_abs_b, w_quo, w_rem;
    logic signed [WIDTH:0]   w_sum, w_b_acc;
    logic [WIDTH-1:0]        w_b_q;
    logic [2*WIDTH-1:0]      w_prod;
    logic [WIDTH:0]          w_rsh, w_d_acc;
    logic [WIDTH+1:0]        w_diff;
    logic                    w_ge;
    logic [WIDTH-1:0]        w_d_q;

    md_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.i_x(bus.a), .i_neg(bus.a[WIDTH-1]), .o_y(w_abs_a));
    md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.i_x(bus.b), .i_neg(bus.b[WIDTH-1]), .o_y(w_abs_b));
    md_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.i_x(w_d_q), .i_neg(r_qneg), .o_y(w_quo));
    md_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.i_x(w_d_acc[WIDTH-1:0]), .i_neg(r_rneg), .o_y(w_rem));

    assign w_div0 = (bus.op == MD_OP_DIV) && (bus.b == '0);

`ifdef MD_SHORTCUT_EN
    assign w_short = (bus.op == MD_OP_MULT) ? ((bus.a == '0) || (bus.b == '0))
                                            : (w_abs_a < w_abs_b);
`else
    assign w_short = 1'b0;
`endif

    // Booth step: add/subtract multiplicand per {q0,q-1}, then arithmetic shift of {acc,q}
    always_comb begin
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
    end
    assign w_b_acc = w_sum >>> 1;
    assign w_b_q   = {w_sum[0], r_q[WIDTH-1:1]};
    assign w_prod  = {w_b_acc[WIDTH-1:0], w_b_q};

    // Restoring step on magnitudes: shift next dividend bit into the partial remainder, trial subtract
    assign w_rsh   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_diff  = {1'b0, w_rsh} - {1'b0, r_m};
    assign w_ge    = ~w_diff[WIDTH+1];
    assign w_d_acc = w_ge ? w_diff[WIDTH:0] : w_rsh;
    assign w_d_q   = {r_q[WIDTH-2:0], w_ge};

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_fin    = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (w_div0 || w_short)         w_next = MD_DONE;
                    else if (bus.op == MD_OP_MULT) w_next = MD_MULT;
                    else                           w_next = MD_DIV;
                end
            end
            MD_MULT, MD_DIV: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_next = MD_DONE;
                    w_fin  = 1'b1;
                end
            end
            MD_DONE: w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_resert) begin
        if (i_resert) r_state <= MD_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_resert) begin
        if (i_resert) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            r_wr   <= 1'b0;
        end else begin
            r_done <= (w_next == MD_DONE);
            r_div0 <= w_accept && w_div0;
            r_wr   <= (w_next == MD_DONE) && !(w_accept && w_div0);
            if (w_accept)
                r_cnt <= CNT_W'(WIDTH - 1);
            else if (w_step && (r_cnt != '0))
                r_cnt <= r_cnt - CNT_W'(1);
            if (w_accept && w_short && !w_div0) begin
                r_hi <= (bus.op == MD_OP_MULT) ? '0 : bus.a;
                r_lo <= '0;
            end else if (w_fin) begin
                if (r_state == MD_MULT) begin
                    {r_hi, r_lo} <= w_prod;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    // Operand/iteration registers carry no reset: they are always loaded on accept before use
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_acc  <= '0;
            r_qm1  <= 1'b0;
            r_qneg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_rneg <= bus.a[WIDTH-1];
            if (bus.op == MD_OP_MULT) begin
                r_m <= {bus.a[WIDTH-1], bus.a};
                r_q <= bus.b;
            end else begin
                r_m <= {1'b0, w_abs_b};
                r_q <= w_abs_a;
            end
        end else if (w_step) begin
            if (r_state == MD_MULT) begin
                r_acc <= w_b_acc;
                r_q   <= w_b_q;
                r_qm1 <= r_q[0];
            end else begin
                r_acc <= w_d_acc;
                r_q   <= w_d_q;
            end
        end
    end

    assign bus.busy    = (r_state != MD_IDLE);
    assign bus.done    = r_done;
    assign bus.div0    = r_div0;
    assign bus.WriteHI = r_wr;
    assign bus.WriteLO = r_wr;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: table of MULT/DIV vectors plus corner sequences (div0, ignored start, async reset).
module tb_md_sequencer;
    import md_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic resert;

    md_sequencer_if #(.WIDTH(WIDTH)) bus ();

    md_sequencer #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_resert(resert),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        int          id;
        logic        div0;
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    vec_t        tbl[14];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          op_id = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic int exp_lat(input logic op, input logic signed [31:0] a,
                                   input logic signed [31:0] b);
        longint la, lb;
        la = a; lb = b;
        if (la < 0) la = -la;
        if (lb < 0) lb = -lb;
        if (op == MD_OP_DIV && lb == 0) return 0;
`ifdef MD_SHORTCUT_EN
        if (op == MD_OP_MULT && (la == 0 || lb == 0)) return 0;
        if (op == MD_OP_DIV && la < lb) return 0;
`endif
        return WIDTH;
    endfunction

    task automatic model(input logic op, input logic signed [31:0] a, input logic signed [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint p, q, r;
        if (op == MD_OP_MULT) begin
            p  = longint'(a) * longint'(b);
            hi = p[63:32];
            lo = p[31:0];
        end else begin
            q  = longint'(a) / longint'(b);
            r  = longint'(a) % longint'(b);
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse pops one expected completion
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                m_e = exp_q.pop_front();
                chk($sformatf("op%0d_hi", m_e.id), bus.hi, m_e.hi);
                chk($sformatf("op%0d_lo", m_e.id), bus.lo, m_e.lo);
                chk($sformatf("op%0d_div0", m_e.id), 32'(bus.div0), 32'(m_e.div0));
                chk($sformatf("op%0d_WriteHI", m_e.id), 32'(bus.WriteHI), 32'(!m_e.div0));
                chk($sformatf("op%0d_WriteLO", m_e.id), 32'(bus.WriteLO), 32'(!m_e.div0));
                chk($sformatf("op%0d_latency", m_e.id), 32'(cyc - m_e.acc), 32'(m_e.lat));
            end
        end
    end

    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int glitch);
        exp_t e;
        int   nb;
        op_id++;
        e.id   = op_id;
        e.div0 = (op == MD_OP_DIV) && (b == 32'd0);
        if (e.div0) begin
            e.hi = m_hi;
            e.lo = m_lo;
        end else begin
            e.hi = eh;
            e.lo = el;
            m_hi = eh;
            m_lo = el;
        end
        e.lat = exp_lat(op, a, b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        nb = 0;
        while (bus.busy === 1'b1 && nb < 200) begin
            nb++;
            if (nb == glitch) begin
                bus.start = 1'b1; bus.op = MD_OP_DIV; bus.a = 32'd1; bus.b = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk($sformatf("op%0d_busy_cycles", e.id), 32'(nb), 32'(e.lat + 1));
        chk($sformatf("op%0d_drained", e.id), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] rh, rl, ra, rb;
        logic        rop;

        tbl[0]  = '{MD_OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[1]  = '{MD_OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[2]  = '{MD_OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        tbl[3]  = '{MD_OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tbl[4]  = '{MD_OP_MULT, 32'd0,        32'd12345,    32'h00000000, 32'h00000000};
        tbl[5]  = '{MD_OP_MULT, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
        tbl[6]  = '{MD_OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[7]  = '{MD_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[8]  = '{MD_OP_DIV,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
        tbl[9]  = '{MD_OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
        tbl[10] = '{MD_OP_DIV,  32'd3,        32'd9,        32'h00000003, 32'h00000000};
        tbl[11] = '{MD_OP_DIV,  32'hFFFFFFFD, 32'd9,        32'hFFFFFFFD, 32'h00000000};
        tbl[12] = '{MD_OP_DIV,  32'h7FFFFFFF, 32'd1,        32'h00000000, 32'h7FFFFFFF};
        tbl[13] = '{MD_OP_DIV,  32'h80000000, 32'h80000000, 32'h00000000, 32'h00000001};

        resert = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_div0",    32'(bus.div0),    32'd0);
        chk("rst_WriteHI", 32'(bus.WriteHI), 32'd0);
        chk("rst_WriteLO", 32'(bus.WriteLO), 32'd0);
        chk("rst_hi",      bus.hi,           32'd0);
        chk("rst_lo",      bus.lo,           32'd0);
        @(negedge clk) resert = 1'b0;

        for (int i = 0; i < 14; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, -1);

        // 0x1234 * 0x1236 / 0x1235 leaves quotient = remainder = 0x1234, then divide by zero
        do_op(MD_OP_DIV, 32'd21724920, 32'h1235, 32'h1234, 32'h1234, -1);
        do_op(MD_OP_DIV, 32'd5, 32'd0, 32'h0, 32'h0, -1);
        chk("div0_hi_hold", bus.hi, 32'h1234);
        chk("div0_lo_hold", bus.lo, 32'h1234);

        // Second start at step 10 of a MULT must be ignored
        do_op(MD_OP_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("glitch_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a DIV
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = MD_OP_DIV; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #3 resert = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_hi",   bus.hi,        32'd0);
        chk("midrst_lo",   bus.lo,        32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk) resert = 1'b0;
        do_op(MD_OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, -1);

        for (int i = 0; i < 6; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = (i % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            rb  = $urandom;
            if (rop == MD_OP_DIV && rb == 32'd0) rb = 32'd1;
            model(rop, ra, rb, rh, rl);
            do_op(rop, ra, rb, rh, rl, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
